// File: rtl/present_sbox_layer_detect_pkg.sv
// PRESENT S-box table and FSM state encoding shared by the S-box layer blocks.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package present_pkg;

    // PRESENT 4-bit S-box, indexed by the input nibble
    localparam logic [3:0] PRESENT_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Control FSM encoding: IDLE -> CALC -> [CHECK] -> HOLD -> IDLE
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_CALC  = 2'd1;
    localparam fsm_state_t ST_CHECK = 2'd2;
    localparam fsm_state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/present_sbox_keyadd.sv
// NIBBLES parallel PRESENT S-boxes followed by a bitwise round-key XOR.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns all sequencing.
module present_sbox_keyadd
    import present_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic [4*NIBBLES-1:0] state,
    input  logic [4*NIBBLES-1:0] key,
    output logic [4*NIBBLES-1:0] result
);

    // Substitute every lane, then mix in the matching key nibble
    always_comb begin
        result = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            result[4*i +: 4] = PRESENT_SBOX[state[4*i +: 4]] ^ key[4*i +: 4];
        end
    end

endmodule

// File: rtl/present_sbox_layer_detect.sv
// PRESENT S-box + key-add layer with redundant evaluation and mismatch alarm.
// Latency: accept -> io_out_valid 2 cycles (spatial) or 3 cycles (temporal).
// Backpressure: one transaction in flight; io_in_ready low until the result handshakes out.
module present_sbox_layer_detect
    import present_pkg::*;
#(
    parameter int NIBBLES    = 16,
    parameter int REDUNDANCY = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [4*NIBBLES-1:0] io_state,
    input  logic [4*NIBBLES-1:0] io_key,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [4*NIBBLES-1:0] io_out,
    output logic                 io_out_fault,
    output logic                 io_error,
    input  logic                 io_error_clear,
    output logic [CNT_W-1:0]     io_fault_count
);

    localparam int              W        = 4 * NIBBLES;
    localparam bit              TEMPORAL = (REDUNDANCY != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fsm_state_t       fsm_q;
    logic [W-1:0]     state_q;
    logic [W-1:0]     key_q;
    logic [W-1:0]     out_q;
    logic             out_vld_q;
    logic             fault_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;

    logic [W-1:0]     y0;          // primary evaluation
    logic [W-1:0]     y1;          // reference the primary is compared against
    logic             in_fire;
    logic             result_load;
    logic             mismatch;

    // All outputs come straight from registers; no input reaches an output combinationally
    assign io_in_ready    = (fsm_q == ST_IDLE);
    assign io_out_valid   = out_vld_q;
    assign io_out         = out_q;
    assign io_out_fault   = fault_q;
    assign io_error       = error_q;
    assign io_fault_count = count_q;

    assign in_fire     = io_in_valid && (fsm_q == ST_IDLE);
    assign result_load = TEMPORAL ? (fsm_q == ST_CHECK) : (fsm_q == ST_CALC);
    assign mismatch    = (y0 != y1);

    (* keep_hierarchy = "yes" *)
    present_sbox_keyadd #(.NIBBLES(NIBBLES)) u_copy0 (
        .state  (state_q),
        .key    (key_q),
        .result (y0)
    );

    generate
        if (TEMPORAL) begin : g_temporal
            logic [W-1:0] first_q;

            // First pass result is held so the second pass on the same hardware can be checked against it
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    first_q <= '0;
                end else if (fsm_q == ST_CALC) begin
                    first_q <= y0;
                end
            end

            assign y1 = first_q;
        end else begin : g_spatial
            logic [W-1:0] state_dup_q;
            logic [W-1:0] key_dup_q;

            // Private input copy for the second datapath so an upset in either register set is visible
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_dup_q <= '0;
                    key_dup_q   <= '0;
                end else if (in_fire) begin
                    state_dup_q <= io_state;
                    key_dup_q   <= io_key;
                end
            end

            (* keep_hierarchy = "yes" *)
            present_sbox_keyadd #(.NIBBLES(NIBBLES)) u_copy1 (
                .state  (state_dup_q),
                .key    (key_dup_q),
                .result (y1)
            );
        end
    endgenerate

    // Control FSM and input capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        state_q <= io_state;
                        key_q   <= io_key;
                        fsm_q   <= ST_CALC;
                    end
                end
                ST_CALC:  fsm_q <= TEMPORAL ? ST_CHECK : ST_HOLD;
                ST_CHECK: fsm_q <= ST_HOLD;
                ST_HOLD: begin
                    if (io_out_ready) begin
                        fsm_q <= ST_IDLE;
                    end
                end
                default:  fsm_q <= ST_IDLE;
            endcase
        end
    end

    // Result register: a faulted transaction is forced to zero so no corrupted data leaves the block
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            fault_q   <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (result_load) begin
            out_q     <= mismatch ? '0 : y0;
            fault_q   <= mismatch;
            out_vld_q <= 1'b1;
        end else if ((fsm_q == ST_HOLD) && io_out_ready) begin
            out_q     <= '0;
            fault_q   <= 1'b0;
            out_vld_q <= 1'b0;
        end
    end

    // Sticky alarm: a new mismatch beats a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (result_load && mismatch) begin
            error_q <= 1'b1;
        end else if (io_error_clear) begin
            error_q <= 1'b0;
        end
    end

    // Saturating count of faulted transactions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (result_load && mismatch && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_present_sbox_layer_detect.sv
// Bench for the PRESENT S-box layer: spatial 16-nibble instance and temporal 1-nibble instance.
// Latency: checks 2/3-cycle accept-to-valid and HOLD stability under stalls.
// Backpressure: io_out_ready is held low for chosen cycles to exercise HOLD.
module tb_present_sbox_layer_detect;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    // Spatial, 16 nibbles, 8-bit counter
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, fault_s, error_s, clear_s;
    logic [63:0] state_s, key_s, out_s;
    logic [7:0]  count_s;

    // Temporal, 1 nibble, 2-bit counter
    logic        in_valid_t, in_ready_t, out_valid_t, out_ready_t, fault_t, error_t, clear_t;
    logic [3:0]  state_t, key_t, out_t;
    logic [1:0]  count_t;

    present_sbox_layer_detect #(.NIBBLES(16), .REDUNDANCY(0), .CNT_W(8)) dut_s (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid_s), .io_in_ready(in_ready_s),
        .io_state(state_s), .io_key(key_s),
        .io_out_valid(out_valid_s), .io_out_ready(out_ready_s),
        .io_out(out_s), .io_out_fault(fault_s), .io_error(error_s),
        .io_error_clear(clear_s), .io_fault_count(count_s)
    );

    present_sbox_layer_detect #(.NIBBLES(1), .REDUNDANCY(1), .CNT_W(2)) dut_t (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid_t), .io_in_ready(in_ready_t),
        .io_state(state_t), .io_key(key_t),
        .io_out_valid(out_valid_t), .io_out_ready(out_ready_t),
        .io_out(out_t), .io_out_fault(fault_t), .io_error(error_t),
        .io_error_clear(clear_t), .io_fault_count(count_t)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] fv_s;
    logic [3:0]  fv_t;

    int sbox_ref [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    typedef struct {
        logic [63:0] st;
        logic [63:0] key;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [6];

    // Reference: substitute each of n nibbles via the table, then XOR the key over n nibbles
    function automatic logic [63:0] model(input logic [63:0] s, input logic [63:0] k, input int n);
        logic [63:0] r;
        logic [63:0] m;
        int idx;
        r = '0;
        m = '0;
        for (int i = 0; i < n; i++) begin
            idx = int'((s >> (4 * i)) & 64'hF);
            r   = r | (64'(sbox_ref[idx]) << (4 * i));
            m   = m | (64'hF << (4 * i));
        end
        return r ^ (k & m);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] cur_out(input bit t);
        return t ? {60'd0, out_t} : out_s;
    endfunction
    function automatic logic cur_valid(input bit t);
        return t ? out_valid_t : out_valid_s;
    endfunction
    function automatic logic cur_fault(input bit t);
        return t ? fault_t : fault_s;
    endfunction
    function automatic logic cur_ready(input bit t);
        return t ? in_ready_t : in_ready_s;
    endfunction

    task automatic drive_in(input bit t, input logic v, input logic [63:0] st, input logic [63:0] k);
        if (t) begin
            in_valid_t = v; state_t = st[3:0]; key_t = k[3:0];
        end else begin
            in_valid_s = v; state_s = st; key_s = k;
        end
    endtask

    task automatic set_clear(input bit t, input logic v);
        if (t) clear_t = v; else clear_s = v;
    endtask

    task automatic set_ready(input bit t, input logic v);
        if (t) out_ready_t = v; else out_ready_s = v;
    endtask

    // One full transaction; optionally corrupts the checking evaluation and/or pulses clear alongside it
    task automatic run_txn(input bit t, input logic [63:0] st, input logic [63:0] k, input int stall,
                           input bit inj, input bit clr, output logic [63:0] out, output logic flt,
                           output int lat, output bit hs_ok);
        int f;
        logic [63:0] good;
        good = model(st, k, t ? 1 : 16);
        fv_s = good ^ 64'h20;
        fv_t = good[3:0] ^ 4'h2;
        f     = t ? 2 : 1;
        lat   = 0;
        hs_ok = 1'b1;
        out   = '0;
        flt   = 1'b0;
        @(negedge clock);
        if (!cur_ready(t)) hs_ok = 1'b0;
        drive_in(t, 1'b1, st, k);
        @(posedge clock);
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            drive_in(t, 1'b0, st, k);
            if (inj && lat == f) begin
                if (t) force dut_t.y0 = fv_t;
                else   force dut_s.y1 = fv_s;
                if (clr) set_clear(t, 1'b1);
            end
            if (inj && lat == f + 1) begin
                if (t) release dut_t.y0;
                else   release dut_s.y1;
                set_clear(t, 1'b0);
            end
            if (cur_valid(t)) break;
        end
        if (!cur_valid(t)) begin
            if (inj) begin
                if (t) release dut_t.y0;
                else   release dut_s.y1;
            end
            n_total++;
            $display("FAIL out_valid_timeout: io_out_valid still 0 after 20 cycles, required 1");
            return;
        end
        out = cur_out(t);
        flt = cur_fault(t);
        repeat (stall) begin
            @(negedge clock);
            if (!cur_valid(t) || cur_out(t) !== out || cur_fault(t) !== flt || cur_ready(t)) hs_ok = 1'b0;
        end
        set_ready(t, 1'b1);
        @(posedge clock);
        @(negedge clock);
        set_ready(t, 1'b0);
        if (cur_valid(t) || !cur_ready(t) || cur_out(t) !== 64'd0) hs_ok = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] out, st, k;
        logic flt, seen;
        int lat, stall;
        bit ok;

        vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 64'hC56B90AD3EF84712};
        vecs[1] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, ~64'hC56B90AD3EF84712};
        vecs[2] = '{64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h2222222222222222};
        vecs[4] = '{64'h0, 64'h0123456789ABCDEF, 64'hCDEF89AB45670123};
        vecs[5] = '{64'hFEDCBA9876543210, 64'h0, 64'h21748FE3DA09B65C};

        reset = 1'b1;
        drive_in(0, 1'b0, 64'd0, 64'd0);
        drive_in(1, 1'b0, 64'd0, 64'd0);
        out_ready_s = 1'b0; out_ready_t = 1'b0;
        clear_s = 1'b0; clear_t = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_in_ready_s", in_ready_s, 1);
        check("rst_out_valid_s", out_valid_s, 0);
        check("rst_out_s", out_s, 0);
        check("rst_fault_s", fault_s, 0);
        check("rst_error_s", error_s, 0);
        check("rst_count_s", count_s, 0);
        check("rst_in_ready_t", in_ready_t, 1);
        check("rst_out_valid_t", out_valid_t, 0);
        check("rst_count_t", count_t, 0);
        reset = 1'b0;

        // Known-answer table on the spatial instance
        for (int i = 0; i < 6; i++) begin
            run_txn(0, vecs[i].st, vecs[i].key, 0, 0, 0, out, flt, lat, ok);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp);
            check($sformatf("vec%0d_model", i), model(vecs[i].st, vecs[i].key, 16), vecs[i].exp);
            check($sformatf("vec%0d_fault", i), flt, 0);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_handshake", i), ok, 1);
        end

        // Random traffic with random output stalls
        for (int i = 0; i < 20; i++) begin
            st    = {$urandom, $urandom};
            k     = {$urandom, $urandom};
            stall = $urandom_range(0, 3);
            run_txn(0, st, k, stall, 0, 0, out, flt, lat, ok);
            check($sformatf("rand%0d_out", i), out, model(st, k, 16));
            check($sformatf("rand%0d_fault", i), flt, 0);
            check($sformatf("rand%0d_handshake", i), ok, 1);
        end

        // Five-cycle stall in HOLD
        run_txn(0, 64'h0123456789ABCDEF, 64'h0, 5, 0, 0, out, flt, lat, ok);
        check("stall5_out", out, 64'hC56B90AD3EF84712);
        check("stall5_stable_then_ready", ok, 1);

        // Injected mismatch on the second copy
        run_txn(0, 64'h0123456789ABCDEF, 64'h0, 1, 1, 0, out, flt, lat, ok);
        check("fault_out_zero", out, 0);
        check("fault_flag", flt, 1);
        check("fault_error", error_s, 1);
        check("fault_count1", count_s, 1);
        check("fault_handshake", ok, 1);
        run_txn(0, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, out, flt, lat, ok);
        check("post_fault_out", out, ~64'hC56B90AD3EF84712);
        check("post_fault_flag", flt, 0);
        check("post_fault_error_sticky", error_s, 1);
        check("post_fault_count", count_s, 1);

        // Clear alone, then clear coinciding with a new mismatch
        @(negedge clock); clear_s = 1'b1;
        @(negedge clock); clear_s = 1'b0;
        check("clear_alone", error_s, 0);
        run_txn(0, 64'h55AA55AA12345678, 64'h0F0F0F0F0F0F0F0F, 0, 1, 1, out, flt, lat, ok);
        check("set_beats_clear", error_s, 1);
        check("set_clear_fault", flt, 1);
        check("count2", count_s, 2);

        // Temporal instance: latency 3, known answer and random
        run_txn(1, 64'h0, 64'h0, 0, 0, 0, out, flt, lat, ok);
        check("t_zero_out", out, 64'hC);
        check("t_zero_fault", flt, 0);
        check("t_latency", lat, 3);
        check("t_handshake", ok, 1);
        for (int i = 0; i < 6; i++) begin
            st = 64'($urandom_range(0, 15));
            k  = 64'($urandom_range(0, 15));
            run_txn(1, st, k, $urandom_range(0, 2), 0, 0, out, flt, lat, ok);
            check($sformatf("t_rand%0d_out", i), out, model(st, k, 1));
        end

        // Temporal second-pass corruption, five times on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            st = 64'($urandom_range(0, 15));
            run_txn(1, st, 64'h0, 0, 1, 0, out, flt, lat, ok);
            check($sformatf("t_fault%0d_out", i), out, 0);
            check($sformatf("t_fault%0d_flag", i), flt, 1);
        end
        check("t_count_saturated", count_t, 3);
        check("t_error", error_t, 1);
        run_txn(1, 64'h9, 64'h3, 0, 0, 0, out, flt, lat, ok);
        check("t_post_fault_out", out, 64'hD);
        check("t_post_fault_error_sticky", error_t, 1);

        // Reset while the spatial instance is in CALC
        @(negedge clock);
        drive_in(0, 1'b1, 64'h0123456789ABCDEF, 64'h0);
        @(posedge clock);
        @(negedge clock);
        drive_in(0, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready_s, 1);
        check("midrst_out_valid", out_valid_s, 0);
        check("midrst_out", out_s, 0);
        check("midrst_fault", fault_s, 0);
        check("midrst_error", error_s, 0);
        check("midrst_count", count_s, 0);
        check("midrst_count_t", count_t, 0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid_s) seen = 1'b1;
        end
        check("midrst_no_output", seen, 0);
        run_txn(0, 64'hFEDCBA9876543210, 64'h0, 0, 0, 0, out, flt, lat, ok);
        check("after_rst_out", out, 64'h21748FE3DA09B65C);
        check("after_rst_latency", lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
